// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants for the MAC datapath: controller state encoding and accumulator width.
package mac_seq_ctrl_pkg;

   localparam int ACC_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: feeds operand pairs to an external mac_unit one at a time,
// chaining each mac_dout back as the next addend, and returns bias + sum(a*b).
module mac_seq_ctrl
   import mac_seq_ctrl_pkg::*;
#(
   parameter int N     = 16,
   parameter int LEN_W = 10,
   parameter int TMO   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [ACC_W-1:0] bias,
   output logic             busy,
   output logic             err_tmo,
   input  logic             op_vld,
   output logic             op_rdy,
   input  logic [N-1:0]     op_a,
   input  logic [N-1:0]     op_b,
   output logic             mac_addend_vld,
   output logic [ACC_W-1:0] mac_addend,
   output logic             mac_mcand_vld,
   output logic [N-1:0]     mac_mcand,
   output logic [N-1:0]     mac_mlier,
   input  logic [ACC_W-1:0] mac_dout,
   input  logic             mac_dout_vld,
   output logic             res_vld,
   input  logic             res_rdy,
   output logic [ACC_W-1:0] res_data
);

   localparam int WD_W = $clog2(TMO + 1);

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] tap;
   logic [ACC_W-1:0] acc;
   logic [WD_W-1:0]  wdog;

   // wdog==0 marks the first WAIT cycle, where mac_dout_vld is left over from the previous tap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         len_q          <= '0;
         tap            <= '0;
         acc            <= '0;
         wdog           <= '0;
         busy           <= 1'b0;
         err_tmo        <= 1'b0;
         op_rdy         <= 1'b0;
         mac_addend_vld <= 1'b0;
         mac_mcand_vld  <= 1'b0;
         mac_addend     <= '0;
         mac_mcand      <= '0;
         mac_mlier      <= '0;
         res_vld        <= 1'b0;
         res_data       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  len_q   <= cfg_len;
                  acc     <= bias;
                  tap     <= '0;
                  err_tmo <= 1'b0;
                  busy    <= 1'b1;
                  if (cfg_len == '0) begin
                     res_data <= bias;
                     res_vld  <= 1'b1;
                     state    <= S_OUT;
                  end else begin
                     op_rdy <= 1'b1;
                     state  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (op_vld && op_rdy) begin
                  op_rdy         <= 1'b0;
                  mac_mcand      <= op_a;
                  mac_mlier      <= op_b;
                  mac_addend     <= acc;
                  mac_addend_vld <= 1'b1;
                  mac_mcand_vld  <= 1'b1;
                  state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mac_addend_vld <= 1'b0;
               mac_mcand_vld  <= 1'b0;
               wdog           <= '0;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               if (wdog != '0 && mac_dout_vld) begin
                  acc <= mac_dout;
                  tap <= tap + 1'b1;
                  if (tap + 1'b1 == len_q) begin
                     res_data <= mac_dout;
                     res_vld  <= 1'b1;
                     state    <= S_OUT;
                  end else begin
                     op_rdy <= 1'b1;
                     state  <= S_FETCH;
                  end
               end else if (wdog == WD_W'(TMO - 1)) begin
                  err_tmo  <= 1'b1;
                  res_data <= acc;
                  res_vld  <= 1'b1;
                  state    <= S_OUT;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_OUT: begin
               if (res_rdy) begin
                  res_vld <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl paired with a behavioural mac_unit that has random latency
// and reads the multiplier combinationally at completion.
module tb_mac_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  cfg_len;
   logic [31:0] bias;
   logic        busy;
   logic        err_tmo;
   logic        op_vld;
   logic        op_rdy;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        mac_addend_vld;
   logic [31:0] mac_addend;
   logic        mac_mcand_vld;
   logic [15:0] mac_mcand;
   logic [15:0] mac_mlier;
   logic [31:0] mac_dout;
   logic        mac_dout_vld;
   logic        res_vld;
   logic        res_rdy;
   logic [31:0] res_data;

   int n_vec = 0;
   int n_err = 0;
   int issue_cnt = 0;
   int hang_issue = 0;
   logic [15:0] a_q[$];
   logic [15:0] b_q[$];

   typedef struct {
      logic [31:0]       bias;
      logic [9:0]        len;
      int                nops;
      logic [3:0][15:0]  a;
      logic [3:0][15:0]  b;
      int                hang;
      int                hold;
      bit                poke;
      logic [31:0]       res_exp;
      bit                err_exp;
   } job_t;

   job_t jobs[8];

   mac_seq_ctrl #(.N(16), .LEN_W(10), .TMO(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .bias(bias),
      .busy(busy), .err_tmo(err_tmo), .op_vld(op_vld), .op_rdy(op_rdy),
      .op_a(op_a), .op_b(op_b), .mac_addend_vld(mac_addend_vld), .mac_addend(mac_addend),
      .mac_mcand_vld(mac_mcand_vld), .mac_mcand(mac_mcand), .mac_mlier(mac_mlier),
      .mac_dout(mac_dout), .mac_dout_vld(mac_dout_vld), .res_vld(res_vld),
      .res_rdy(res_rdy), .res_data(res_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // mac_unit model: optional stale pulse in the first cycle after issue, then a 1-8 cycle wait.
   always begin
      logic [31:0]        m_addend;
      logic [15:0]        exp_a;
      logic [15:0]        exp_b;
      logic signed [31:0] prod;
      bit                 stale;
      int                 gap;
      @(negedge clk);
      if (rst_n && mac_addend_vld && mac_mcand_vld) begin
         issue_cnt++;
         m_addend = mac_addend;
         exp_a = (a_q.size() > 0) ? a_q.pop_front() : 16'hxxxx;
         exp_b = (b_q.size() > 0) ? b_q.pop_front() : 16'hxxxx;
         checkOutput("mcand_at_issue", {16'h0, mac_mcand}, {16'h0, exp_a});
         checkOutput("mlier_at_issue", {16'h0, mac_mlier}, {16'h0, exp_b});
         if (issue_cnt != hang_issue) begin
            stale = 1'($urandom_range(0, 1));
            gap   = $urandom_range(0, 7);
            @(posedge clk);
            #1;
            if (stale) begin
               mac_dout_vld = 1'b1;
               mac_dout     = 32'hDEADBEEF;
            end
            @(posedge clk);
            #1;
            mac_dout_vld = 1'b0;
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
            checkOutput("mlier_hold_in_wait", {16'h0, mac_mlier}, {16'h0, exp_b});
            prod = $signed(mac_mcand) * $signed(mac_mlier);
            mac_dout     = m_addend + prod;
            mac_dout_vld = 1'b1;
            @(posedge clk);
            #1;
            mac_dout_vld = 1'b0;
         end
      end
   end

   function automatic job_t mk(input logic [31:0] bs, input logic [9:0] ln, input int nops,
                               input logic [3:0][15:0] a, input logic [3:0][15:0] b,
                               input int hang, input int hold, input bit poke,
                               input logic [31:0] rexp, input bit eexp);
      job_t j;
      j.bias = bs; j.len = ln; j.nops = nops; j.a = a; j.b = b;
      j.hang = hang; j.hold = hold; j.poke = poke; j.res_exp = rexp; j.err_exp = eexp;
      return j;
   endfunction

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      int cnt = 0;
      repeat ($urandom_range(0, 3)) tick();
      op_vld = 1'b1;
      op_a   = a;
      op_b   = b;
      while (!op_rdy && cnt < 300) begin
         tick();
         cnt++;
      end
      checkOutput("op_accept", {31'h0, op_rdy}, 32'h1);
      if (op_rdy) begin
         a_q.push_back(a);
         b_q.push_back(b);
      end
      tick();
      op_vld = 1'b0;
   endtask

   task automatic runJob(input job_t j);
      int base = issue_cnt;
      int cnt = 0;
      hang_issue = (j.hang > 0) ? issue_cnt + j.hang : 0;
      start   = 1'b1;
      cfg_len = j.len;
      bias    = j.bias;
      tick();
      start   = 1'b0;
      cfg_len = 10'h3FF;
      bias    = 32'h5555AAAA;
      checkOutput("busy_after_start", {31'h0, busy}, 32'h1);
      checkOutput("err_cleared_by_start", {31'h0, err_tmo}, 32'h0);
      if (j.len == 0) checkOutput("len0_res_vld_early", {31'h0, res_vld}, 32'h1);
      for (int i = 0; i < j.nops; i++) applyStimulus(j.a[i], j.b[i]);
      if (j.poke) begin
         start   = 1'b1;
         cfg_len = 10'd1;
         bias    = 32'd999;
         tick();
         start   = 1'b0;
      end
      while (!res_vld && cnt < 400) begin
         tick();
         cnt++;
      end
      checkOutput("res_vld", {31'h0, res_vld}, 32'h1);
      checkOutput("res_data", res_data, j.res_exp);
      checkOutput("err_tmo", {31'h0, err_tmo}, {31'h0, j.err_exp});
      for (int h = 0; h < j.hold; h++) begin
         tick();
         checkOutput("res_data_held", res_data, j.res_exp);
         checkOutput("op_rdy_in_out", {31'h0, op_rdy}, 32'h0);
      end
      res_rdy = 1'b1;
      if (j.poke) start = 1'b1;
      tick();
      res_rdy = 1'b0;
      start   = 1'b0;
      checkOutput("busy_after_handshake", {31'h0, busy}, 32'h0);
      checkOutput("res_vld_after_handshake", {31'h0, res_vld}, 32'h0);
      checkOutput("mac_issue_count", issue_cnt - base, j.nops);
      hang_issue = 0;
      repeat (2) tick();
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("[TB] FAIL global_timeout: got expired, want finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; cfg_len = '0; bias = '0; op_vld = 1'b0;
      op_a = '0; op_b = '0; mac_dout = '0; mac_dout_vld = 1'b0; res_rdy = 1'b0;

      jobs[0] = mk(32'd100, 10'd3, 3, {16'd0, 16'd1, 16'd4, 16'd2}, {16'd0, 16'd1, 16'd5, 16'd3},
                   0, 10, 1'b0, 32'd127, 1'b0);
      jobs[1] = mk(32'hFFFFFFF9, 10'd0, 0, '0, '0, 0, 0, 1'b0, 32'hFFFFFFF9, 1'b0);
      jobs[2] = mk(32'd1000, 10'd2, 2, {16'd0, 16'd0, 16'd3, 16'd2}, {16'd0, 16'd0, 16'd3, 16'd2},
                   0, 0, 1'b1, 32'd1013, 1'b0);
      jobs[3] = mk(32'd10, 10'd3, 2, {16'd0, 16'd1, 16'd4, 16'd2}, {16'd0, 16'd1, 16'd4, 16'd3},
                   2, 0, 1'b0, 32'd16, 1'b1);
      jobs[4] = mk(32'd5, 10'd1, 1, {48'h0, 16'hFFFD}, {48'h0, 16'hFFFD}, 0, 0, 1'b0, 32'd14, 1'b0);
      jobs[5] = mk(32'h7FFFFFFF, 10'd1, 1, {48'h0, 16'd1}, {48'h0, 16'd1}, 0, 0, 1'b0,
                   32'h80000000, 1'b0);
      jobs[6] = mk(32'd0, 10'd4, 4, {4{16'h7FFF}}, {4{16'h7FFF}}, 0, 0, 1'b0, 32'hFFFC0004, 1'b0);
      jobs[7] = mk(32'd0, 10'd3, 3, {16'd0, 16'h8000, 16'd0, 16'hFFFF},
                   {16'd0, 16'h8000, 16'd5, 16'd1}, 0, 3, 1'b0, 32'h3FFFFFFF, 1'b0);

      repeat (3) tick();
      checkOutput("rst_busy", {31'h0, busy}, 32'h0);
      checkOutput("rst_err_tmo", {31'h0, err_tmo}, 32'h0);
      checkOutput("rst_op_rdy", {31'h0, op_rdy}, 32'h0);
      checkOutput("rst_mac_vlds", {30'h0, mac_addend_vld, mac_mcand_vld}, 32'h0);
      checkOutput("rst_res_vld", {31'h0, res_vld}, 32'h0);
      checkOutput("rst_res_data", res_data, 32'h0);
      checkOutput("rst_mac_addend", mac_addend, 32'h0);
      checkOutput("rst_mac_ops", {mac_mcand, mac_mlier}, 32'h0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 8; k++) runJob(jobs[k]);

      // Reset while tap 2 is outstanding, then a fresh job must be unaffected.
      hang_issue = issue_cnt + 2;
      start = 1'b1; cfg_len = 10'd3; bias = 32'd50;
      tick();
      start = 1'b0;
      applyStimulus(16'd7, 16'd7);
      applyStimulus(16'd9, 16'd9);
      repeat (10) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      hang_issue = 0;
      checkOutput("abort_busy", {31'h0, busy}, 32'h0);
      checkOutput("abort_res_vld", {31'h0, res_vld}, 32'h0);
      checkOutput("abort_op_rdy", {31'h0, op_rdy}, 32'h0);
      tick();
      runJob(mk(32'd0, 10'd2, 2, {16'd0, 16'd0, 16'hFFFE, 16'd3}, {16'd0, 16'd0, 16'd4, 16'd3},
                0, 0, 1'b0, 32'd1, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
